matrix_scan_ctrl: RTL and testbench
===================================

// Module: matrix_scan_ctrl
// PURPOSE
//  Time-multiplexed column scanner for the 5x7 LED dot matrix. Holds a double-buffered 5x7 frame
//  and drives one column at a time (one-hot col_out, 7-bit row_out), with blanking between columns
//  to avoid ghosting. Upstream selection logic writes columns into the shadow buffer and requests
//  a swap; the swap is applied only at a frame boundary, so a partial image is never displayed.
// PARAMETERS
//  DWELL    1000  clock cycles each column is driven (>=1)
//  BLANK    4     clock cycles all columns are off before each column (>=1)
//  ROW_POL  1     1: row_out active-high; 0: row_out inverted (inactive level = ~ROW_POL)
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  en          in   1  scan enable; 0 = display off
//  wr_en       in   1  write request to shadow buffer
//  wr_col      in   3  column index 0..4 for write
//  wr_data     in   7  row bits for that column, bit0 = top row
//  wr_ready    out  1  shadow buffer writable (write accepted when wr_en & wr_ready)
//  swap_req    in   1  pulse: commit shadow buffer to active buffer at next frame boundary
//  swap_ack    out  1  1-cycle pulse when the commit happens
//  col_out     out  5  one-hot column drive, col_out[i] = column i, active-high
//  row_out     out  7  row data for driven column, polarity per ROW_POL
//  cur_col     out  3  index of current column (0..4)
//  frame_start out  1  1-cycle pulse on entry to BLANK of column 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): state OFF, cur_col=0, counter=0, both buffers all-zero, swap pending=0;
//    col_out=0, row_out=inactive, wr_ready=1, swap_ack=0, frame_start=0.
//  - FSM states OFF, BLANK, DRIVE. en sampled every cycle; en=0 in any state -> OFF on next edge.
//    OFF --en=1--> BLANK(col 0) with frame_start=1. BLANK lasts exactly BLANK cycles, then DRIVE.
//    DRIVE lasts exactly DWELL cycles, then BLANK of col+1; after col 4 wraps to col 0 (frame
//    boundary) with frame_start=1. Column period = BLANK+DWELL; frame = 5*(BLANK+DWELL).
//  - col_out = onehot(cur_col) only in DRIVE, else 0. row_out = active[cur_col] (polarity-adjusted)
//    in DRIVE, else inactive. Both decoded from registered state only (glitch-free).
//  - Latency: first cycle with en=1 sampled -> col_out=5'b00001 after BLANK+1 edges.
//  - Down-counter width $clog2(max(DWELL,BLANK)+1); reloaded on every state change; cleared in OFF.
//  - Writes: wr_en & wr_ready & wr_col<=4 -> shadow[wr_col]<=wr_data. wr_col>4 silently ignored.
//  - swap_req sets pending; wr_ready=0 while pending. swap_req while pending is merged (no effect).
//  - Commit: on the DRIVE(col4)->BLANK(col0) edge, if pending: active<=shadow, pending<=0,
//    swap_ack=1 in the same cycle as frame_start. In OFF, pending commits on the next edge.
//  - Same cycle wr_en (accepted) and swap_req: the write lands and is included in the commit.
//  - en dropping mid-column: outputs go off on next edge; re-enable restarts at col 0 with
//    frame_start; active buffer retained. Reset mid-operation clears everything asynchronously.
//  - Shadow buffer is not cleared by a swap (incremental updates allowed).
// STRUCTURE
//  - Shared package matrix_pkg: NUM_COLS=5, NUM_ROWS=7, COL_W=3, scan state enum {OFF,BLANK,DRIVE}.
//  - Sub-module matrix_frame_buf: shadow+active 5x7 registers, write port, swap input, column read.
//  - Top holds FSM, counter, pending flag, output decode.
// TESTING (DWELL=8, BLANK=2, ROW_POL=1 unless noted)
//  1 Reset then en=1: col_out=0 for 3 edges, then 00001 for 8 cycles, 00000 for 2, 00010 for 8...;
//    frame_start every 50 cycles; wrap 10000->00001.
//  2 Write cols 0..4 = 7'h01,02,04,08,10, swap_req: wr_ready=0 until boundary, swap_ack coincides
//    with frame_start, next frame row_out in DRIVE = 01,02,04,08,10; prior frame unchanged (all 0).
//  3 wr_en with wr_col=5 then swap: active buffer unchanged; second swap_req while pending -> one ack.
//  4 Write col2=7'h7F in same cycle as swap_req: committed frame shows 7F on col 2.
//  5 Drop en during DRIVE col 3: col_out=0, row_out=0 next edge; re-enable -> restarts col 0.
//    Pending swap with en=0 -> swap_ack next edge.
//  6 ROW_POL=0, col0=7'h05: row_out=7'h7A in DRIVE col 0, 7'h7F in BLANK/OFF; async reset mid-DRIVE
//    -> outputs inactive without a clock edge.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants and scan-state encoding for the 5x7 LED matrix column scanner.
package matrix_pkg;
  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;
  localparam int COL_W    = 3;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } scan_state_e;
endpackage

// File: rtl/matrix_frame_buf.sv
// Double-buffered 5x7 frame store: shadow is written column by column, active is what the scanner reads.
module matrix_frame_buf
  import matrix_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [COL_W-1:0]    wr_col,
  input  logic [NUM_ROWS-1:0] wr_data,
  input  logic                swap,
  input  logic [COL_W-1:0]    rd_col,
  output logic [NUM_ROWS-1:0] rd_data
);
  logic [NUM_COLS-1:0][NUM_ROWS-1:0] shadow_q, shadow_d;
  logic [NUM_COLS-1:0][NUM_ROWS-1:0] active_q, active_d;

  // wr_en arrives already qualified (ready and in-range column), so no range check here.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en) shadow_d[wr_col] = wr_data;
    if (swap) active_d = shadow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign rd_data = active_q[rd_col];
endmodule

// File: rtl/matrix_scan_ctrl.sv
// Column scanner: OFF/BLANK/DRIVE FSM with down-counter, frame-boundary swap commit and output decode.
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int DWELL   = 1000,
  parameter int BLANK   = 4,
  parameter int ROW_POL = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                wr_en,
  input  logic [COL_W-1:0]    wr_col,
  input  logic [NUM_ROWS-1:0] wr_data,
  output logic                wr_ready,
  input  logic                swap_req,
  output logic                swap_ack,
  output logic [NUM_COLS-1:0] col_out,
  output logic [NUM_ROWS-1:0] row_out,
  output logic [COL_W-1:0]    cur_col,
  output logic                frame_start,
  output logic [1:0]          dbg_state
);
  localparam int MAX_CNT = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  scan_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               pending_q, pending_d;
  logic               frame_start_q, frame_start_d;
  logic               swap_ack_q, swap_ack_d;
  logic               boundary;
  logic               commit;
  logic               wr_accept;
  logic [NUM_ROWS-1:0] rd_data;
  logic [NUM_ROWS-1:0] row_act;

  // Write handshake: a write is taken on a rising edge where wr_en && wr_ready;
  // out-of-range columns are dropped without stalling the writer.
  assign wr_ready  = ~pending_q;
  assign wr_accept = wr_en & wr_ready & (wr_col < COL_W'(NUM_COLS));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    col_d         = col_q;
    frame_start_d = 1'b0;
    boundary      = 1'b0;
    if (!en) begin
      state_d = S_OFF;
      cnt_d   = '0;
      col_d   = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d       = S_BLANK;
          cnt_d         = CNT_W'(BLANK - 1);
          col_d         = '0;
          frame_start_d = 1'b1;
        end
        S_BLANK: begin
          if (cnt_q == '0) begin
            state_d = S_DRIVE;
            cnt_d   = CNT_W'(DWELL - 1);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_DRIVE: begin
          if (cnt_q == '0) begin
            state_d = S_BLANK;
            cnt_d   = CNT_W'(BLANK - 1);
            if (col_q == LAST_COL) begin
              col_d         = '0;
              frame_start_d = 1'b1;
              boundary      = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
          col_d   = '0;
        end
      endcase
    end
  end

  // A pending swap commits at the frame wrap, or immediately while the display is off.
  always_comb begin
    commit     = pending_q & (boundary | (state_q == S_OFF));
    swap_ack_d = commit;
    pending_d  = commit ? 1'b0 : (pending_q | swap_req);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_OFF;
      cnt_q         <= '0;
      col_q         <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      swap_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      swap_ack_q    <= swap_ack_d;
    end
  end

  matrix_frame_buf u_frame_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_accept),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .swap    (commit),
    .rd_col  (col_q),
    .rd_data (rd_data)
  );

  always_comb begin
    col_out = '0;
    row_act = '0;
    if (state_q == S_DRIVE) begin
      col_out = {{(NUM_COLS-1){1'b0}}, 1'b1} << col_q;
      row_act = rd_data;
    end
    row_out = (ROW_POL != 0) ? row_act : ~row_act;
  end

  assign cur_col     = col_q;
  assign frame_start = frame_start_q;
  assign swap_ack    = swap_ack_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl with DWELL=8, BLANK=2; a second ROW_POL=0 instance shares the stimulus.
module tb_matrix_scan_ctrl;
  import matrix_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       wr_en;
  logic [2:0] wr_col;
  logic [6:0] wr_data;
  logic       swap_req;

  logic       wr_ready,  wr_ready_n;
  logic       swap_ack,  swap_ack_n;
  logic [4:0] col_out,   col_out_n;
  logic [6:0] row_out,   row_out_n;
  logic [2:0] cur_col,   cur_col_n;
  logic       frame_start, frame_start_n;
  logic [1:0] dbg_state, dbg_state_n;

  int errors = 0;
  int checks = 0;
  logic [6:0] img [5];

  matrix_scan_ctrl #(.DWELL(8), .BLANK(2), .ROW_POL(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_col(wr_col),
    .wr_data(wr_data), .wr_ready(wr_ready), .swap_req(swap_req), .swap_ack(swap_ack),
    .col_out(col_out), .row_out(row_out), .cur_col(cur_col),
    .frame_start(frame_start), .dbg_state(dbg_state)
  );

  matrix_scan_ctrl #(.DWELL(8), .BLANK(2), .ROW_POL(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_col(wr_col),
    .wr_data(wr_data), .wr_ready(wr_ready_n), .swap_req(swap_req), .swap_ack(swap_ack_n),
    .col_out(col_out_n), .row_out(row_out_n), .cur_col(cur_col_n),
    .frame_start(frame_start_n), .dbg_state(dbg_state_n)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-position model: p = cycles since the frame_start cycle, column period 10 (2 blank + 8 drive).
  function automatic logic [4:0] m_col(input int p);
    logic [4:0] one;
    one = 5'b00001;
    if ((p % 10) >= 2) return one << (p / 10);
    return 5'b00000;
  endfunction

  function automatic logic [6:0] m_row(input int p);
    if ((p % 10) >= 2) return img[p / 10];
    return 7'h00;
  endfunction

  task automatic sync_frame();
    bit found;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL sync_frame: frame_start not seen within 60 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_col = 3'd0; wr_data = 7'h00; swap_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (col_out !== 5'h00) begin errors++; $display("FAIL rst_col_out got %b exp 00000", col_out); end
    checks++; if (row_out !== 7'h00) begin errors++; $display("FAIL rst_row_out got %h exp 00", row_out); end
    checks++; if (row_out_n !== 7'h7F) begin errors++; $display("FAIL rst_row_out_n got %h exp 7f", row_out_n); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %b exp 1", wr_ready); end
    checks++; if (swap_ack !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL rst_pulses got ack=%b fs=%b exp 0 0", swap_ack, frame_start); end
    checks++; if (cur_col !== 3'd0 || dbg_state !== 2'(S_OFF)) begin errors++; $display("FAIL rst_state got col=%0d st=%0d exp 0 0", cur_col, dbg_state); end
  endtask

  task automatic test_scan();
    for (int c = 0; c < 5; c++) img[c] = 7'h00;
    rst_n = 1'b1;
    en    = 1'b1;
    for (int t = 0; t < 110; t++) begin
      @(negedge clk);
      checks++; if (col_out !== m_col(t % 50)) begin errors++; $display("FAIL scan_col_out t=%0d got %b exp %b", t, col_out, m_col(t % 50)); end
      checks++; if (frame_start !== ((t % 50) == 0)) begin errors++; $display("FAIL scan_frame_start t=%0d got %b", t, frame_start); end
      checks++; if (cur_col !== 3'((t % 50) / 10)) begin errors++; $display("FAIL scan_cur_col t=%0d got %0d exp %0d", t, cur_col, (t % 50) / 10); end
    end
  endtask

  task automatic test_swap();
    sync_frame();
    for (int c = 0; c < 5; c++) begin
      wr_en = 1'b1; wr_col = 3'(c); wr_data = 7'h01 << c;
      @(negedge clk);
    end
    wr_en = 1'b0; swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    for (int p = 6; p < 50; p++) begin
      if (p > 6) @(negedge clk);
      checks++; if (wr_ready !== 1'b0 || swap_ack !== 1'b0) begin errors++; $display("FAIL swap_pending p=%0d got rdy=%b ack=%b exp 0 0", p, wr_ready, swap_ack); end
      checks++; if (row_out !== 7'h00) begin errors++; $display("FAIL swap_old_frame p=%0d got %h exp 00", p, row_out); end
    end
    @(negedge clk);
    checks++; if (frame_start !== 1'b1 || swap_ack !== 1'b1 || wr_ready !== 1'b1) begin errors++; $display("FAIL swap_commit got fs=%b ack=%b rdy=%b exp 1 1 1", frame_start, swap_ack, wr_ready); end
    for (int c = 0; c < 5; c++) img[c] = 7'h01 << c;
    for (int p = 1; p < 50; p++) begin
      @(negedge clk);
      checks++; if (row_out !== m_row(p) || col_out !== m_col(p)) begin errors++; $display("FAIL swap_new_frame p=%0d got row=%h col=%b exp %h %b", p, row_out, col_out, m_row(p), m_col(p)); end
    end
  endtask

  task automatic test_ignore_and_merge();
    int acks;
    bit seen;
    sync_frame();
    wr_en = 1'b1; wr_col = 3'd5; wr_data = 7'h7F;
    @(negedge clk);
    wr_en = 1'b0; swap_req = 1'b1;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL merge_ready got %b exp 0", wr_ready); end
    @(negedge clk);
    swap_req = 1'b0;
    acks = 0; seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (swap_ack === 1'b1) acks++;
      if (frame_start === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    checks++; if (!seen || acks != 1 || swap_ack !== 1'b1) begin errors++; $display("FAIL merge_acks got acks=%0d seen=%b ack_at_fs=%b exp 1 1 1", acks, seen, swap_ack); end
    for (int p = 1; p < 50; p++) begin
      @(negedge clk);
      checks++; if (row_out !== m_row(p)) begin errors++; $display("FAIL ignore_col5 p=%0d got %h exp %h", p, row_out, m_row(p)); end
    end
  endtask

  task automatic test_write_with_swap();
    sync_frame();
    wr_en = 1'b1; wr_col = 3'd2; wr_data = 7'h7F; swap_req = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; swap_req = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL wsw_ready got %b exp 0", wr_ready); end
    sync_frame();
    checks++; if (swap_ack !== 1'b1) begin errors++; $display("FAIL wsw_ack got %b exp 1", swap_ack); end
    img[2] = 7'h7F;
    for (int p = 1; p < 50; p++) begin
      @(negedge clk);
      checks++; if (row_out !== m_row(p)) begin errors++; $display("FAIL wsw_frame p=%0d got %h exp %h", p, row_out, m_row(p)); end
    end
  endtask

  task automatic test_disable();
    sync_frame();
    repeat (34) @(negedge clk);
    checks++; if (col_out !== 5'b01000 || row_out !== 7'h08 || cur_col !== 3'd3) begin errors++; $display("FAIL dis_col3 got col=%b row=%h cur=%0d exp 01000 08 3", col_out, row_out, cur_col); end
    en = 1'b0; wr_en = 1'b1; wr_col = 3'd0; wr_data = 7'h05; swap_req = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; swap_req = 1'b0;
    checks++; if (col_out !== 5'h00 || row_out !== 7'h00 || cur_col !== 3'd0) begin errors++; $display("FAIL dis_off got col=%b row=%h cur=%0d exp 00000 00 0", col_out, row_out, cur_col); end
    checks++; if (dbg_state !== 2'(S_OFF) || swap_ack !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL dis_pending got st=%0d ack=%b rdy=%b exp 0 0 0", dbg_state, swap_ack, wr_ready); end
    @(negedge clk);
    checks++; if (swap_ack !== 1'b1 || wr_ready !== 1'b1) begin errors++; $display("FAIL dis_commit got ack=%b rdy=%b exp 1 1", swap_ack, wr_ready); end
    @(negedge clk);
    checks++; if (swap_ack !== 1'b0) begin errors++; $display("FAIL dis_ack_pulse got %b exp 0", swap_ack); end
    en = 1'b1;
    @(negedge clk);
    checks++; if (frame_start !== 1'b1 || col_out !== 5'h00 || cur_col !== 3'd0) begin errors++; $display("FAIL dis_restart got fs=%b col=%b cur=%0d exp 1 00000 0", frame_start, col_out, cur_col); end
    repeat (2) @(negedge clk);
    checks++; if (col_out !== 5'b00001 || row_out !== 7'h05 || row_out_n !== 7'h7A) begin errors++; $display("FAIL dis_resume got col=%b row=%h rown=%h exp 00001 05 7a", col_out, row_out, row_out_n); end
  endtask

  task automatic test_polarity_and_async_reset();
    sync_frame();
    checks++; if (row_out_n !== 7'h7F || row_out !== 7'h00) begin errors++; $display("FAIL pol_blank got rown=%h row=%h exp 7f 00", row_out_n, row_out); end
    repeat (2) @(negedge clk);
    checks++; if (row_out_n !== 7'h7A || col_out_n !== 5'b00001) begin errors++; $display("FAIL pol_drive got rown=%h coln=%b exp 7a 00001", row_out_n, col_out_n); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (col_out !== 5'h00 || row_out !== 7'h00 || row_out_n !== 7'h7F) begin errors++; $display("FAIL arst_outputs got col=%b row=%h rown=%h exp 00000 00 7f", col_out, row_out, row_out_n); end
    checks++; if (cur_col !== 3'd0 || wr_ready !== 1'b1 || dbg_state !== 2'(S_OFF)) begin errors++; $display("FAIL arst_state got cur=%0d rdy=%b st=%0d exp 0 1 0", cur_col, wr_ready, dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL arst_restart got fs=%b exp 1", frame_start); end
    repeat (2) @(negedge clk);
    checks++; if (col_out !== 5'b00001 || row_out !== 7'h00 || row_out_n !== 7'h7F) begin errors++; $display("FAIL arst_cleared got col=%b row=%h rown=%h exp 00001 00 7f", col_out, row_out, row_out_n); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_swap();
    test_ignore_and_merge();
    test_write_with_swap();
    test_disable();
    test_polarity_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
